braun_divider: RTL and testbench

BRAUN_DIVIDER -- requirements
Module: braun_divider

---
 rtl/braun_divider.sv | 115 +++++++++++
 tb/tb_braun_divider.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/braun_divider.sv
// braun_divider: 8-bit / 4-bit restoring divider, one quotient bit per cycle.
// Define DIV0_ERR_EN to add the div0 flag and a single-cycle divide-by-zero path.
module braun_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] p,
    input  logic [3:0] y,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       busy,
    output logic       done
`ifdef DIV0_ERR_EN
    ,
    output logic       div0
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  rem_q, rem_d;
    logic [7:0]  dvd_q, dvd_d;
    logic [3:0]  dvs_q, dvs_d;
    logic [7:0]  quo_q, quo_d;
    logic [7:0]  q_q, q_d;
    logic [3:0]  r_q, r_d;
    logic [4:0]  sh, nrem;
    logic        ge;
    // A zero divisor always "fits", so the quotient fills with ones and the dividend's low nibble remains.
    assign sh   = {rem_q, dvd_q[7]};
    assign ge   = sh >= {1'b0, dvs_q};
    assign nrem = ge ? sh - {1'b0, dvs_q} : sh;
`ifdef DIV0_ERR_EN
    logic div0_q, div0_d;
    assign div0 = div0_q;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIV0_ERR_EN
        div0_d  = 1'b0;
`endif
        case (state_q)
            IDLE: if (start) begin
`ifdef DIV0_ERR_EN
                if (y == 4'd0) begin
                    state_d = DONE;
                    q_d     = 8'hFF;
                    r_d     = p[3:0];
                    div0_d  = 1'b1;
                end else begin
`else
                begin
`endif
                    state_d = RUN;
                    dvd_d   = p;
                    dvs_d   = y;
                    rem_d   = 4'd0;
                    cnt_d   = 3'd0;
                    quo_d   = 8'd0;
                end
            end
            RUN: begin
                rem_d = nrem[3:0];
                dvd_d = {dvd_q[6:0], 1'b0};
                quo_d = {quo_q[6:0], ge};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                    q_d     = {quo_q[6:0], ge};
                    r_d     = nrem[3:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rem_q   <= 4'd0;
            dvd_q   <= 8'd0;
            dvs_q   <= 4'd0;
            quo_q   <= 8'd0;
            q_q     <= 8'd0;
            r_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end
`ifdef DIV0_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_q <= 1'b0;
        else        div0_q <= div0_d;
    end
`endif
    assign q    = q_q;
    assign r    = r_q;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
endmodule

// File: tb/tb_braun_divider.sv
// tb_braun_divider: scoreboard bench for braun_divider; expected results queued at start, checked on done.
module tb_braun_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] p = 8'd0;
    logic [3:0] y = 4'd0;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy, done;
`ifdef DIV0_ERR_EN
    logic       div0;
    localparam bit FAST0 = 1'b1;
`else
    localparam bit FAST0 = 1'b0;
`endif
    int n_tests = 0, n_fail = 0, n_done = 0;
    logic [12:0] exp_q[$];

    braun_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p(p), .y(y),
        .q(q), .r(r), .busy(busy), .done(done)
`ifdef DIV0_ERR_EN
        , .div0(div0)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] qq, rr;
        if (b == 4'd0) return {FAST0, 8'hFF, a[3:0]};
        qq = a / {4'd0, b};
        rr = a % {4'd0, b};
        return {1'b0, qq, rr[3:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [12:0] e;
            n_done++;
            if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("q", q, e[11:4]);
                check("r", r, e[3:0]);
`ifdef DIV0_ERR_EN
                check("div0", div0, e[12]);
`endif
            end
        end
    end

    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        p = a;
        y = b;
        start = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        p = ~a;
        y = ~b;
    endtask

    task automatic wait_done(input string tag, input int lat_exp, input int busy_exp);
        int cyc = 0, bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, lat_exp);
        check({tag, "_busy"}, bcnt, busy_exp);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        int d0;
        #1;
        check("rst_q", q, 8'd0);
        check("rst_r", r, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(8'd143, 4'd13);
        wait_done("mul_inv", 8, 8);
        check("mul_inv_qr", {q, r}, {8'd11, 4'd0});
        launch(8'd255, 4'd1);  wait_done("c255_1", 8, 8);
        launch(8'd100, 4'd7);  wait_done("c100_7", 8, 8);
        check("c100_7_qr", {q, r}, {8'd14, 4'd2});
        launch(8'd0, 4'd5);    wait_done("c0_5", 8, 8);
        launch(8'd15, 4'd15);  wait_done("c15_15", 8, 8);

        d0 = n_done;
        launch(8'd200, 4'd7);
        repeat (7) begin
            @(negedge clk);
            start = 1'b1;
            p = 8'($urandom);
            y = 4'($urandom_range(1, 15));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("busy_start_dones", n_done - d0, 1);
        check("busy_start_qr", {q, r}, {8'd28, 4'd4});

        launch(8'hA7, 4'd0);
        if (FAST0) wait_done("div0", 0, 0);
        else       wait_done("div0", 8, 8);
        check("div0_qr", {q, r}, {8'hFF, 4'h7});

        d0 = n_done;
        launch(8'd143, 4'd13);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        check("abort_q", q, 8'd0);
        check("abort_r", r, 4'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", n_done - d0, 0);
        launch(8'd200, 4'd9);
        wait_done("post_rst", 8, 8);
        check("post_rst_qr", {q, r}, {8'd22, 4'd2});

        for (int a = 0; a < 256; a++)
            for (int b = 1; b < 16; b++) begin
                launch(8'(a), 4'(b));
                wait_done("sweep", 8, 8);
            end
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
